// File: rtl/vscale_dmem_responder_if.sv
// Data-memory bus between the core (master) and the dmem responder (slave).
// Request fields are driven by the core; wait/error/read data come back.
interface vscale_dmem_responder_if;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;

    modport master (
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_wait, dmem_badmem_e
    );

    modport slave (
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_wait, dmem_badmem_e
    );
endinterface

// File: rtl/vscale_dmem_responder.sv
// Memory-side end of the core's dmem port: word RAM with byte-lane stores,
// programmable wait states and alignment/range error reporting.
module vscale_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    vscale_dmem_responder_if.slave        bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hold_data;
    logic        hold_err;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          misaligned;
    logic          bad_size;
    logic          err;
    logic          accept;
    logic [3:0]    mask;
    logic [31:0]   wdata_rep;
    logic [31:0]   ld_data;

    // Decode the request: word index, error flag, byte mask and lane data.
    always_comb begin
        offset     = bus.dmem_addr - BASE_ADDR;
        idx        = AW'(offset >> 2);
        in_range   = ({1'b0, bus.dmem_addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.dmem_addr} < LIMIT);
        bad_size   = (bus.dmem_size == 3'd3) || (bus.dmem_size[2:1] == 2'b11);
        misaligned = 1'b0;
        mask       = 4'b1111;
        wdata_rep  = bus.dmem_wdata;
        case (bus.dmem_size[1:0])
            2'd0: begin
                mask      = 4'b0001 << bus.dmem_addr[1:0];
                wdata_rep = {4{bus.dmem_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = bus.dmem_addr[0];
                mask       = bus.dmem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{bus.dmem_wdata[15:0]}};
            end
            2'd2: misaligned = (bus.dmem_addr[1:0] != 2'd0);
            default: misaligned = 1'b0;
        endcase
        err     = bad_size || misaligned || !in_range;
        accept  = bus.dmem_en && !bus.dmem_wait;
        ld_data = (err || bus.dmem_wen) ? 32'h0 : mem[idx];
    end

    // Stores commit at the accept edge; errored stores are dropped.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.dmem_wen && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Request/response sequencing with registered wait, error and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= 4'd0;
            hold_data         <= 32'h0;
            hold_err          <= 1'b0;
            bus.dmem_wait     <= 1'b0;
            bus.dmem_badmem_e <= 1'b0;
            bus.dmem_rdata    <= 32'h0;
        end else begin
            bus.dmem_wait     <= 1'b0;
            bus.dmem_badmem_e <= 1'b0;
            bus.dmem_rdata    <= 32'h0;
            unique case (state)
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state             <= S_RESP;
                        bus.dmem_rdata    <= hold_data;
                        bus.dmem_badmem_e <= hold_err;
                    end else begin
                        cnt           <= cnt - 4'd1;
                        bus.dmem_wait <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state             <= S_RESP;
                            bus.dmem_rdata    <= ld_data;
                            bus.dmem_badmem_e <= err;
                        end else begin
                            state         <= S_WAIT;
                            cnt           <= CNT_INIT;
                            bus.dmem_wait <= 1'b1;
                            hold_data     <= ld_data;
                            hold_err      <= err;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
